// File: rtl/user_input_pkg.sv
// Shared types and sizing helpers for the up/down value entry block.
//   deb_state_t : debounce FSM states
//   BTN_UP/DN   : bit positions of the two buttons in the per-button vectors
//   cnt_width() : counter width that holds the largest of the cycle counts
// Optional feature macro: USER_INPUT_AUTO_REPEAT_EN (see btn_debounce).
package user_input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } deb_state_t;

    localparam int NUM_BTNS = 2;
    localparam int BTN_UP   = 0;
    localparam int BTN_DN   = 1;

    localparam int DEF_DEB_CYCLES    = 50000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;

    function automatic int cnt_width(input int deb, input int rd, input int rp);
        int m;
        m = deb;
        if (rd > m) m = rd;
        if (rp > m) m = rp;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_DEB_CYCLES, DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD);

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-FF synchroniser followed by a
// press/release debounce FSM. Emits a one-cycle step pulse per accepted press.
// With USER_INPUT_AUTO_REPEAT_EN defined, a held button also emits repeat
// steps: first after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD.
// Ports:
//   clk   : board clock
//   rst_n : asynchronous active-low reset
//   btn_n : raw asynchronous button, 0 = pressed
//   step  : registered one-cycle step pulse
module btn_debounce
    import user_input_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic step
);

    localparam int CW = cnt_width(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic          sync;
    deb_state_t    state;
    logic [CW-1:0] cnt;

    assign sync = sync_ff[1];

`ifdef USER_INPUT_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RPT_DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_PER_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] rpt_cnt;
    logic          rpt_first;   // still waiting for the initial (longer) delay
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff   <= 2'b11;     // released
            state     <= IDLE;
            cnt       <= '0;
            step      <= 1'b0;
`ifdef USER_INPUT_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            sync_ff <= {sync_ff[0], btn_n};
            step    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sync) begin
                        state <= PRESS_CHK;
                        cnt   <= CW'(1);
                    end
                end
                PRESS_CHK: begin
                    if (sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= HELD;
                        step  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (sync) begin
                        state <= REL_CHK;
                        cnt   <= CW'(1);
`ifdef USER_INPUT_AUTO_REPEAT_EN
                        // Clearing on exit means any later entry into HELD
                        // (including REL_CHK bounce-back) restarts the delay.
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b1;
                    end else if (rpt_cnt == (rpt_first ? RPT_DLY_LAST : RPT_PER_LAST)) begin
                        step      <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
`endif
                    end
                end
                REL_CHK: begin
                    if (!sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/user_input_ctrl.sv
// Two-button (up/down) value entry, fully synchronous to clk. Holds a value in
// 0..MAX_VAL with wrap-around in both directions.
// Optional feature macro: USER_INPUT_AUTO_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk, rst_n : board clock, asynchronous active-low reset
//   btn_up_n   : raw up button, 0 = pressed
//   btn_dn_n   : raw down button, 0 = pressed
//   enable     : 0 forces data to 0 and discards steps
//   data       : current value
//   changed    : one-cycle pulse when data changes
//   wrapped    : one-cycle pulse when a step wraps around
module user_input_ctrl
    import user_input_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MAX_VAL       = 15,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    input  logic             enable,
    output logic [WIDTH-1:0] data,
    output logic             changed,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [NUM_BTNS-1:0] btn_n_vec;
    logic [NUM_BTNS-1:0] step_vec;
    logic                up;
    logic                dn;

    assign btn_n_vec[BTN_UP] = btn_up_n;
    assign btn_n_vec[BTN_DN] = btn_dn_n;
    assign up = step_vec[BTN_UP];
    assign dn = step_vec[BTN_DN];

    btn_debounce #(
        .DEB_CYCLES   (DEB_CYCLES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_deb [NUM_BTNS-1:0] (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_n_vec),
        .step (step_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            changed <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            changed <= 1'b0;
            wrapped <= 1'b0;
            if (!enable) begin
                data    <= '0;
                changed <= (data != '0);
            end else if (up && !dn) begin
                // With MAX_VAL >= 1 every step moves data, so changed is unconditional.
                changed <= 1'b1;
                if (data == MAX_V) begin
                    data    <= '0;
                    wrapped <= 1'b1;
                end else begin
                    data <= data + 1'b1;
                end
            end else if (dn && !up) begin
                changed <= 1'b1;
                if (data == '0) begin
                    data    <= MAX_V;
                    wrapped <= 1'b1;
                end else begin
                    data <= data - 1'b1;
                end
            end
            // Simultaneous up and down cancel.
        end
    end

endmodule
